// File: rtl/init_value_sequencer.sv
// Fills a register bank with BASE + i*STEP, then streams it round-robin; host can overwrite entries.
// Latency: init_done NUM_REGS cycles after reset/restart, first word one cycle later, then 1 word/cycle.
// Backpressure: out_data/out_idx hold while out_valid && !out_ready; restart discards any pending word.
module init_value_sequencer #(
  parameter int          NUM_REGS = 4,
  parameter logic [7:0]  BASE     = 8'h10,
  parameter logic [7:0]  STEP     = 8'h10,
  localparam int         AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_err,
  output logic          init_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [AW-1:0] out_idx
);

  localparam int          LAST_I = NUM_REGS - 1;
  localparam logic [AW-1:0] LAST = LAST_I[AW-1:0];
  localparam logic [AW:0]   NUM_W = NUM_REGS[AW:0];

  typedef enum logic {LOAD, RUN} state_t;

  state_t        state;
  logic [AW-1:0] load_cnt;
  logic [AW-1:0] ptr;
  logic [7:0]    bank [NUM_REGS];

  logic          addr_ok;
  logic          fwd;
  logic          advance;
  logic [7:0]    fill_val;
  logic [AW-1:0] ptr_next;

  // Address range check, same-cycle write forwarding and the fill constant for the current slot.
  always_comb begin
    addr_ok  = ({1'b0, wr_addr} < NUM_W);
    fwd      = wr_en && (wr_addr == ptr);
    advance  = !out_valid || out_ready;
    fill_val = BASE + STEP * 8'(load_cnt);
    ptr_next = (ptr == LAST) ? '0 : ptr + 1'b1;
  end

  // Bank storage: fill writes during LOAD, host writes during RUN; restart blocks both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else if (!restart) begin
      if (state == LOAD) begin
        bank[load_cnt] <= fill_val;
      end else if (wr_en && addr_ok) begin
        bank[wr_addr] <= wr_data;
      end
    end
  end

  // Sequencer FSM with registered stream outputs and write-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      load_cnt  <= '0;
      ptr       <= '0;
      init_done <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= 1'b0;
      if (restart) begin
        // Restart wins over everything: a same-cycle write is dropped silently.
        state     <= LOAD;
        load_cnt  <= '0;
        ptr       <= '0;
        init_done <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            wr_err   <= wr_en;
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LAST) begin
              state     <= RUN;
              init_done <= 1'b1;
              ptr       <= '0;
              load_cnt  <= '0;
            end
          end
          RUN: begin
            wr_err <= wr_en && !addr_ok;
            if (advance) begin
              // The bank write lands this same edge, so forward it into the output register.
              out_data  <= fwd ? wr_data : bank[ptr];
              out_idx   <= ptr;
              out_valid <= 1'b1;
              ptr       <= ptr_next;
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule
